// File: rtl/frog_collision_manager.sv
// ---------------------------------------------------------------------------
// frog_collision_manager
//
// Purpose:
//   Detects frog/car overlaps and goal-row arrivals, and keeps lives and
//   score. Sends the score and the lane-direction pattern back to the car
//   movement stage. Sends a frog-respawn pulse and the game-state flags to
//   the player controller and the renderer.
//
//   Pipeline:
//     stage 1 registers the per-car hit flags and the goal flag.
//     stage 2 is a registered FSM (PLAY / FREEZE / GAME_OVER / GAME_WON)
//     that acts on those flags.
//   An input sampled at edge N+1 therefore shows up on o_Hit/o_Frog_Reset
//   at edge N+2.
//
// Ports:
//   i_Clk            system clock
//   i_Reset          synchronous, active-high reset
//   i_Car_X_0..5     car left-edge pixel X (10 bits each)
//   i_Frog_X         frog left-edge pixel X (10 bits)
//   i_Frog_Y         frog tile row, 0 = goal row (4 bits)
//   i_Restart        single-cycle pulse; leaves GAME_OVER / GAME_WON
//   o_Score          current score (4 bits)
//   o_Reverse        lane reverse bits (4 bits)
//   o_Lives          remaining lives (3 bits)
//   o_Hit            one-cycle pulse on collision
//   o_Frog_Reset     one-cycle pulse; frog returns to its start tile
//   o_Frozen         high during the post-event freeze
//   o_Game_Over      high in GAME_OVER
//   o_Game_Won       high in GAME_WON
// ---------------------------------------------------------------------------
module frog_collision_manager #(
    parameter int          TILE_SIZE       = 32,
    parameter int          C_START_LIVES   = 3,
    parameter int          C_FREEZE_CYCLES = 25000000,
    parameter int          C_WIN_SCORE     = 15,
    parameter int          C_LANE_ROW_0    = 2,
    parameter int          C_LANE_ROW_1    = 3,
    parameter int          C_LANE_ROW_2    = 4,
    parameter int          C_LANE_ROW_3    = 5,
    parameter int          C_LANE_ROW_4    = 9,
    parameter int          C_LANE_ROW_5    = 10,
    parameter logic [3:0]  C_REVERSE_BASE  = 4'b1010
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [9:0]  i_Car_X_0,
    input  logic [9:0]  i_Car_X_1,
    input  logic [9:0]  i_Car_X_2,
    input  logic [9:0]  i_Car_X_3,
    input  logic [9:0]  i_Car_X_4,
    input  logic [9:0]  i_Car_X_5,
    input  logic [9:0]  i_Frog_X,
    input  logic [3:0]  i_Frog_Y,
    input  logic        i_Restart,
    output logic [3:0]  o_Score,
    output logic [3:0]  o_Reverse,
    output logic [2:0]  o_Lives,
    output logic        o_Hit,
    output logic        o_Frog_Reset,
    output logic        o_Frozen,
    output logic        o_Game_Over,
    output logic        o_Game_Won
);

    localparam logic [3:0]  C_LANE_ROWS [0:5] = '{
        4'(C_LANE_ROW_0), 4'(C_LANE_ROW_1), 4'(C_LANE_ROW_2),
        4'(C_LANE_ROW_3), 4'(C_LANE_ROW_4), 4'(C_LANE_ROW_5)
    };
    localparam logic [24:0] C_FREEZE_LOAD = 25'(C_FREEZE_CYCLES - 1);
    localparam logic [2:0]  C_LIVES_INIT  = 3'(C_START_LIVES);
    localparam logic [3:0]  C_WIN         = 4'(C_WIN_SCORE);
    localparam logic [10:0] C_TILE        = 11'(TILE_SIZE);

    typedef enum logic [1:0] {
        S_PLAY      = 2'd0,
        S_FREEZE    = 2'd1,
        S_GAME_OVER = 2'd2,
        S_GAME_WON  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Stage 1: per-car overlap detection
    // ------------------------------------------------------------------
    logic [9:0] w_car_x [0:5];
    logic [5:0] w_hit_now;

    assign w_car_x[0] = i_Car_X_0;
    assign w_car_x[1] = i_Car_X_1;
    assign w_car_x[2] = i_Car_X_2;
    assign w_car_x[3] = i_Car_X_3;
    assign w_car_x[4] = i_Car_X_4;
    assign w_car_x[5] = i_Car_X_5;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_car
            logic [10:0] w_diff;
            // The distance is an unsigned 11-bit magnitude. There is no
            // screen wrap, so cars at opposite edges never overlap.
            assign w_diff = (w_car_x[gi] >= i_Frog_X)
                          ? ({1'b0, w_car_x[gi]} - {1'b0, i_Frog_X})
                          : ({1'b0, i_Frog_X} - {1'b0, w_car_x[gi]});
            assign w_hit_now[gi] = (i_Frog_Y == C_LANE_ROWS[gi]) && (w_diff < C_TILE);
        end
    endgenerate

    logic [5:0] r_Hit;
    logic       r_Goal;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Hit  <= '0;
            r_Goal <= 1'b0;
        end else begin
            r_Hit  <= w_hit_now;
            r_Goal <= (i_Frog_Y == 4'd0);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: game FSM
    // ------------------------------------------------------------------
    state_t      r_State;
    logic [24:0] r_Freeze_Cnt;
    logic [3:0]  r_Score;
    logic [3:0]  r_Reverse;
    logic [2:0]  r_Lives;
    logic        r_Hit_Pulse;
    logic        r_Frog_Reset;
    logic        r_Frozen;
    logic        r_Game_Over;
    logic        r_Game_Won;

    logic [2:0]  w_lives_dec;
    logic [3:0]  w_score_inc;

    // Both counters saturate, so they can never wrap.
    assign w_lives_dec = (r_Lives == 3'd0) ? 3'd0 : r_Lives - 3'd1;
    assign w_score_inc = (r_Score == 4'hF) ? 4'hF : r_Score + 4'd1;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State      <= S_PLAY;
            r_Freeze_Cnt <= '0;
            r_Score      <= 4'd0;
            r_Reverse    <= C_REVERSE_BASE;
            r_Lives      <= C_LIVES_INIT;
            r_Hit_Pulse  <= 1'b0;
            r_Frog_Reset <= 1'b0;
            r_Frozen     <= 1'b0;
            r_Game_Over  <= 1'b0;
            r_Game_Won   <= 1'b0;
        end else begin
            r_Hit_Pulse  <= 1'b0;
            r_Frog_Reset <= 1'b0;
            case (r_State)
                S_PLAY: begin
                    // A hit wins over a goal. Any number of cars hitting
                    // together costs a single life.
                    if (|r_Hit) begin
                        r_Hit_Pulse  <= 1'b1;
                        r_Frog_Reset <= 1'b1;
                        r_Lives      <= w_lives_dec;
                        if (w_lives_dec == 3'd0) begin
                            r_State     <= S_GAME_OVER;
                            r_Game_Over <= 1'b1;
                        end else begin
                            r_State      <= S_FREEZE;
                            r_Freeze_Cnt <= C_FREEZE_LOAD;
                            r_Frozen     <= 1'b1;
                        end
                    end else if (r_Goal) begin
                        r_Frog_Reset <= 1'b1;
                        r_Score      <= w_score_inc;
                        // Lane directions flip every level.
                        r_Reverse    <= C_REVERSE_BASE ^ {4{w_score_inc[0]}};
                        if (w_score_inc == C_WIN) begin
                            r_State    <= S_GAME_WON;
                            r_Game_Won <= 1'b1;
                        end else begin
                            r_State      <= S_FREEZE;
                            r_Freeze_Cnt <= C_FREEZE_LOAD;
                            r_Frozen     <= 1'b1;
                        end
                    end
                end
                S_FREEZE: begin
                    // The counter is loaded with N-1 and the exit happens
                    // on the edge where it reads 0. That gives exactly N
                    // cycles with o_Frozen high.
                    if (r_Freeze_Cnt == 25'd0) begin
                        r_State  <= S_PLAY;
                        r_Frozen <= 1'b0;
                    end else begin
                        r_Freeze_Cnt <= r_Freeze_Cnt - 25'd1;
                    end
                end
                S_GAME_OVER, S_GAME_WON: begin
                    if (i_Restart) begin
                        r_State      <= S_PLAY;
                        r_Score      <= 4'd0;
                        r_Lives      <= C_LIVES_INIT;
                        r_Reverse    <= C_REVERSE_BASE;
                        r_Frog_Reset <= 1'b1;
                        r_Game_Over  <= 1'b0;
                        r_Game_Won   <= 1'b0;
                    end
                end
                default: r_State <= S_PLAY;
            endcase
        end
    end

    assign o_Score      = r_Score;
    assign o_Reverse    = r_Reverse;
    assign o_Lives      = r_Lives;
    assign o_Hit        = r_Hit_Pulse;
    assign o_Frog_Reset = r_Frog_Reset;
    assign o_Frozen     = r_Frozen;
    assign o_Game_Over  = r_Game_Over;
    assign o_Game_Won   = r_Game_Won;

endmodule

// File: tb/tb_frog_collision_manager.sv
// ---------------------------------------------------------------------------
// tb_frog_collision_manager
//
// Purpose:
//   Directed-vector bench for frog_collision_manager, with a short freeze.
//   A second instance moves car 0's lane onto the goal row. This lets a hit
//   and a goal arrive together, so their priority can be checked.
// ---------------------------------------------------------------------------
module tb_frog_collision_manager;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst2;
    logic [9:0]  car_x [0:5];
    logic [9:0]  frog_x;
    logic [3:0]  frog_y;
    logic        restart;

    logic [3:0]  score, reverse;
    logic [2:0]  lives;
    logic        hit, frog_reset, frozen, game_over, game_won;

    logic [3:0]  score2, reverse2;
    logic [2:0]  lives2;
    logic        hit2, frog_reset2, frozen2, game_over2, game_won2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    frog_collision_manager #(.C_FREEZE_CYCLES(4)) dut (
        .i_Clk(clk), .i_Reset(rst),
        .i_Car_X_0(car_x[0]), .i_Car_X_1(car_x[1]), .i_Car_X_2(car_x[2]),
        .i_Car_X_3(car_x[3]), .i_Car_X_4(car_x[4]), .i_Car_X_5(car_x[5]),
        .i_Frog_X(frog_x), .i_Frog_Y(frog_y), .i_Restart(restart),
        .o_Score(score), .o_Reverse(reverse), .o_Lives(lives),
        .o_Hit(hit), .o_Frog_Reset(frog_reset), .o_Frozen(frozen),
        .o_Game_Over(game_over), .o_Game_Won(game_won)
    );

    frog_collision_manager #(.C_FREEZE_CYCLES(4), .C_LANE_ROW_0(0)) dut_prio (
        .i_Clk(clk), .i_Reset(rst2),
        .i_Car_X_0(car_x[0]), .i_Car_X_1(car_x[1]), .i_Car_X_2(car_x[2]),
        .i_Car_X_3(car_x[3]), .i_Car_X_4(car_x[4]), .i_Car_X_5(car_x[5]),
        .i_Frog_X(frog_x), .i_Frog_Y(frog_y), .i_Restart(restart),
        .o_Score(score2), .o_Reverse(reverse2), .o_Lives(lives2),
        .o_Hit(hit2), .o_Frog_Reset(frog_reset2), .o_Frozen(frozen2),
        .o_Game_Over(game_over2), .o_Game_Won(game_won2)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frog parked on row 12 (no lane, not the goal) with every car far away.
    task automatic idle();
        frog_y = 4'd12;
        frog_x = 10'd0;
        for (int i = 0; i < 6; i++) car_x[i] = 10'd500;
    endtask

    // Frog at row 2, X=100, against car 0. The response is checked two
    // edges later. The bench then waits out any freeze.
    task automatic probe(input string tag, input int c0, input int exp_hit);
        frog_y   = 4'd2;
        frog_x   = 10'd100;
        car_x[0] = 10'(c0);
        step();
        step();
        check_eq({tag, " hit"}, int'(hit), exp_hit);
        idle();
        for (int i = 0; i < 5; i++) step();
    endtask

    // One goal arrival: the frog reaches row 0 for one sample. The
    // frog-reset pulse is checked, then the bench waits out the freeze.
    task automatic do_goal(input string tag);
        frog_y = 4'd0;
        step();
        idle();
        step();
        check_eq({tag, " frog_reset"}, int'(frog_reset), 1);
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        rst     = 1'b1;
        rst2    = 1'b1;
        restart = 1'b0;
        idle();
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_eq("rst score",     int'(score), 0);
        check_eq("rst lives",     int'(lives), 3);
        check_eq("rst reverse",   int'(reverse), 4'b1010);
        check_eq("rst hit",       int'(hit), 0);
        check_eq("rst frog_rst",  int'(frog_reset), 0);
        check_eq("rst frozen",    int'(frozen), 0);
        check_eq("rst game_over", int'(game_over), 0);
        check_eq("rst game_won",  int'(game_won), 0);

        // Overlap boundary: a distance of 32 misses, 31 hits.
        probe("dist32 right", 132, 0);
        probe("dist32 left",  68,  0);
        check_eq("no-hit lives", int'(lives), 3);
        probe("dist31 left",  69,  1);
        check_eq("hit1 lives", int'(lives), 2);

        // Detailed hit timing and freeze length
        frog_y   = 4'd2;
        frog_x   = 10'd100;
        car_x[0] = 10'd120;
        step();
        check_eq("hit2 N+1 hit", int'(hit), 0);
        step();
        check_eq("hit2 N+2 hit",       int'(hit), 1);
        check_eq("hit2 N+2 frog_rst",  int'(frog_reset), 1);
        check_eq("hit2 lives",         int'(lives), 1);
        check_eq("hit2 frozen c1",     int'(frozen), 1);
        idle();
        step();
        check_eq("hit2 pulse width", int'(hit), 0);
        check_eq("hit2 frozen c2",   int'(frozen), 1);
        step();
        check_eq("hit2 frozen c3", int'(frozen), 1);
        step();
        check_eq("hit2 frozen c4", int'(frozen), 1);
        step();
        check_eq("hit2 frozen end", int'(frozen), 0);
        step();

        // Third hit uses car 4 on row 9 and ends the game.
        frog_y   = 4'd9;
        frog_x   = 10'd200;
        car_x[4] = 10'd210;
        step();
        step();
        check_eq("hit3 hit",       int'(hit), 1);
        check_eq("hit3 lives",     int'(lives), 0);
        check_eq("hit3 game_over", int'(game_over), 1);
        check_eq("hit3 frozen",    int'(frozen), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("over ignore hit", int'(hit), 0);
        end
        check_eq("over lives held", int'(lives), 0);
        idle();
        step();
        step();

        // Restart from GAME_OVER
        restart = 1'b1;
        step();
        restart = 1'b0;
        check_eq("restart lives",     int'(lives), 3);
        check_eq("restart score",     int'(score), 0);
        check_eq("restart game_over", int'(game_over), 0);
        check_eq("restart frog_rst",  int'(frog_reset), 1);
        step();
        check_eq("restart pulse end", int'(frog_reset), 0);

        // First goal, holding row 0 into the freeze
        frog_y = 4'd0;
        step();
        step();
        check_eq("goal1 frog_rst", int'(frog_reset), 1);
        check_eq("goal1 score",    int'(score), 1);
        check_eq("goal1 reverse",  int'(reverse), 4'b0101);
        check_eq("goal1 hit",      int'(hit), 0);
        step();
        step();
        check_eq("goal1 held score", int'(score), 1);
        idle();
        for (int i = 0; i < 3; i++) step();
        check_eq("goal1 after freeze", int'(score), 1);
        check_eq("goal1 frozen off",   int'(frozen), 0);

        // Goals up to 14, then the winning goal
        for (int g = 2; g <= 14; g++) do_goal("goal");
        check_eq("score14",         int'(score), 14);
        check_eq("score14 reverse", int'(reverse), 4'b1010);
        do_goal("goal15");
        check_eq("score15",         int'(score), 15);
        check_eq("score15 won",     int'(game_won), 1);
        check_eq("score15 reverse", int'(reverse), 4'b0101);
        frog_y = 4'd0;
        step();
        step();
        step();
        check_eq("won score saturates", int'(score), 15);
        check_eq("won no frog_rst",     int'(frog_reset), 0);
        idle();
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        check_eq("restart2 score", int'(score), 0);
        check_eq("restart2 won",   int'(game_won), 0);
        step();

        // Build score 5 / lives 1, then reset mid-freeze.
        for (int g = 1; g <= 4; g++) do_goal("pre goal");
        probe("pre hit a", 120, 1);
        probe("pre hit b", 120, 1);
        frog_y = 4'd0;
        step();
        idle();
        step();
        check_eq("pre score5",  int'(score), 5);
        check_eq("pre lives1",  int'(lives), 1);
        check_eq("pre frozen",  int'(frozen), 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst score",    int'(score), 0);
        check_eq("midrst lives",    int'(lives), 3);
        check_eq("midrst frozen",   int'(frozen), 0);
        check_eq("midrst reverse",  int'(reverse), 4'b1010);
        check_eq("midrst hit",      int'(hit), 0);
        check_eq("midrst frog_rst", int'(frog_reset), 0);

        // Reset between stage 1 and stage 2: no pulse may emerge.
        frog_y   = 4'd2;
        frog_x   = 10'd100;
        car_x[0] = 10'd120;
        step();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        check_eq("pulse rst hit",      int'(hit), 0);
        check_eq("pulse rst frog_rst", int'(frog_reset), 0);
        step();
        check_eq("pulse rst after hit", int'(hit), 0);
        check_eq("pulse rst lives",     int'(lives), 3);

        // Hit and goal together (car 0 lane on row 0): the hit wins.
        rst2 = 1'b0;
        step();
        frog_y   = 4'd0;
        frog_x   = 10'd100;
        car_x[0] = 10'd100;
        step();
        idle();
        step();
        check_eq("prio hit",   int'(hit2), 1);
        check_eq("prio lives", int'(lives2), 2);
        check_eq("prio score", int'(score2), 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/frog_collision_manager.md
Name: frog_collision_manager

Overview:
- Consumes the six car X positions from the car movement stage, plus the frog position from the player controller.
- Detects frog/car collisions and goal-row arrivals, and maintains lives and score.
- Feeds the score and lane-direction pattern back upstream to the car movement stage.
- Issues a frog-respawn pulse and game-state flags to the player controller and renderer.

Parameters:
- TILE_SIZE, 32, car/frog width in pixels; overlap threshold.
- C_START_LIVES, 3, lives loaded at reset/restart (1..7).
- C_FREEZE_CYCLES, 25000000, post-event freeze length in clocks (1 s at 25 MHz); 25-bit counter.
- C_WIN_SCORE, 15, score that ends the game as won (≤15).
- C_LANE_ROW_0..C_LANE_ROW_5, 2,3,4,5,9,10, tile row occupied by car 0..5.
- C_REVERSE_BASE, 4'b1010, lane direction pattern at even scores.

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Car_X_0..i_Car_X_5  in  10 each  car left-edge pixel X.
- i_Frog_X  in  10  frog left-edge pixel X.
- i_Frog_Y  in  4  frog tile row (0 = goal row).
- i_Restart  in  1  single-cycle pulse; leaves GAME_OVER/GAME_WON.
- o_Score  out  4  current score, to car movement stage.
- o_Reverse  out  4  lane reverse bits, to car movement stage.
- o_Lives  out  3  remaining lives.
- o_Hit  out  1  one-cycle pulse on collision.
- o_Frog_Reset  out  1  one-cycle pulse; frog returns to start tile.
- o_Frozen  out  1  high during freeze.
- o_Game_Over  out  1  high in GAME_OVER.
- o_Game_Won  out  1  high in GAME_WON.

Behaviour:
- Reset values:
  - o_Score=0, o_Lives=C_START_LIVES, o_Reverse=C_REVERSE_BASE.
  - All pulses and flags are 0; state=PLAY; freeze counter=0.
- Stage 1 (registered): per car k, r_Hit[k] = (i_Frog_Y==C_LANE_ROW_k) AND (|i_Frog_X − i_Car_X_k| < TILE_SIZE).
  - Compute the difference in 11-bit unsigned magnitude; no screen wrap.
- Stage 1 also registers r_Goal = (i_Frog_Y==0).
- Stage 2: FSM acts on registered flags. An input at cycle N produces o_Hit/o_Frog_Reset at the N+2 edge.
- PLAY:
  - Any r_Hit set:
    - o_Hit=1, o_Frog_Reset=1, o_Lives−1.
    - If lives becomes 0, go to GAME_OVER; otherwise go to FREEZE with counter=C_FREEZE_CYCLES−1.
  - Else r_Goal:
    - o_Frog_Reset=1, o_Score+1.
    - If the new score == C_WIN_SCORE, go to GAME_WON; otherwise go to FREEZE.
  - Hit has priority over goal when both are set.
  - Multiple simultaneous car hits cost one life.
- FREEZE:
  - o_Frozen=1; collision and goal flags are ignored; counter decrements each cycle.
  - At 0, return to PLAY. Duration is exactly C_FREEZE_CYCLES cycles with o_Frozen high.
- GAME_OVER / GAME_WON:
  - Flags held; score and lives frozen; all detections ignored.
  - i_Restart: score=0, lives=C_START_LIVES, o_Reverse=C_REVERSE_BASE, o_Frog_Reset pulse, go to PLAY.
  - i_Restart in PLAY or FREEZE is ignored.
- o_Reverse = C_REVERSE_BASE XOR {4{o_Score[0]}}.
  - Registered; updates on the same edge as o_Score, so lanes flip direction every level.
- Score saturates at 15; it never wraps.
- Lives never decrement below 0.
- i_Reset mid-freeze or mid-pulse:
  - Next cycle all reset values apply, and the stage-1 flags clear.
  - No pulse is emitted on the reset cycle.

Test Plan:
- Bench overrides C_FREEZE_CYCLES=4.
- Frog at Y=2, X=100; Car_X_0=120 (overlap 20<32) -> o_Hit and o_Frog_Reset pulse at cycle N+2; o_Lives 3→2; o_Frozen high for exactly 4 cycles, then PLAY.
- Frog at Y=2, X=100; Car_X_0=132 (distance 32) -> no hit. Car_X_0=68 -> no hit. Car_X_0=69 -> hit.
- Frog at Y=0 in PLAY -> o_Score 0→1, o_Reverse 1010→0101, o_Frog_Reset pulse. Holding Y=0 through freeze gives no second increment.
- Three hits separated by freezes -> o_Lives 3→0, o_Game_Over=1; further overlaps give no o_Hit. i_Restart -> lives=3, score=0, PLAY, o_Frog_Reset pulse.
- Score 14, frog reaches Y=0 -> score=15, o_Game_Won=1. Overlap on Y=9 with Car_X_4 at the same time as a goal is impossible, so separately force Hit and Goal flags together -> hit wins.
- Assert i_Reset during FREEZE with score=5, lives=1 -> next cycle score=0, lives=3, o_Frozen=0, no pulses.
